bcd_digit_adder: RTL and testbench



---
 rtl/bcd_pkg.sv | 14 +
 rtl/bcd_digit_add.sv | 28 ++
 rtl/bcd_digit_adder.sv | 66 ++++++
 tb/tb_bcd_digit_adder.sv | 137 +++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants, types and helpers for the BCD adder.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

  typedef logic [3:0] bcd_digit_t;

  // True when the nibble is a legal decimal digit (0..9).
  function automatic logic is_bcd(input bcd_digit_t digit);
    return (digit <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit combinational BCD adder with invalid-digit flag.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] sum_i,
  output logic       c_o,
  output logic       bad
);

  logic [4:0] t_raw;
  logic [4:0] t_corr;
  logic       over;

  // Binary add, then decimal-correct when the raw sum leaves the 0..9 range.
  // Invalid inputs push t up to 31; the same correction still applies.
  always_comb begin
    t_raw  = {1'b0, a_i} + {1'b0, b_i} + {4'b0, c_i};
    over   = (t_raw > {1'b0, BCD_MAX});
    t_corr = t_raw + {1'b0, BCD_CORR};
    sum_i  = over ? t_corr[3:0] : t_raw[3:0];
    c_o    = over;
    bad    = !is_bcd(a_i) || !is_bcd(b_i);
  end

endmodule

// File: rtl/bcd_digit_adder.sv
// Registered multi-digit BCD adder: ripple of digit adders plus output register.
module bcd_digit_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                out_valid,
  output logic                err
);

  logic [DIGITS:0]       carry;
  logic [DIGITS-1:0]     bad_vec;
  logic [4*DIGITS-1:0]   sum_next;

  logic [4*DIGITS-1:0]   sum_reg;
  logic                  cout_reg;
  logic                  out_valid_reg;
  logic                  err_reg;

  assign carry[0] = cin;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_digit_add u_digit (
        .a_i   (a[4*gi +: 4]),
        .b_i   (b[4*gi +: 4]),
        .c_i   (carry[gi]),
        .sum_i (sum_next[4*gi +: 4]),
        .c_o   (carry[gi+1]),
        .bad   (bad_vec[gi])
      );
    end
  endgenerate

  // Capture the result on accepted operands; otherwise hold the data and drop valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_reg       <= '0;
      cout_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      out_valid_reg <= in_valid;
      if (in_valid) begin
        sum_reg  <= sum_next;
        cout_reg <= carry[DIGITS];
        err_reg  <= |bad_vec;
      end
    end
  end

  assign sum       = sum_reg;
  assign cout      = cout_reg;
  assign out_valid = out_valid_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_bcd_digit_adder.sv
// Directed self-checking bench for bcd_digit_adder (1-digit and 4-digit instances).
module tb_bcd_digit_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        v1, cin1, v4, cin4;
  logic [3:0]  a1, b1;
  logic [15:0] a4, b4;
  logic [3:0]  sum1;
  logic [15:0] sum4;
  logic        cout1, ov1, err1, cout4, ov4, err4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bcd_digit_adder #(.DIGITS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .cin(cin1),
    .sum(sum1), .cout(cout1), .out_valid(ov1), .err(err1)
  );

  bcd_digit_adder #(.DIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4), .cin(cin4),
    .sum(sum4), .cout(cout4), .out_valid(ov4), .err(err4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One-digit operation: drive at negedge, check just after the capturing edge.
  task automatic op1(input logic [3:0] a, input logic [3:0] b, input logic c,
                     input logic [3:0] es, input logic ec, input logic ee);
    @(negedge clk);
    a1 = a; b1 = b; cin1 = c; v1 = 1'b1;
    @(posedge clk); #1;
    $display("d1 %0h+%0h+%0d -> sum %0h cout %0d err %0d", a, b, c, sum1, cout1, err1);
    check("d1_sum", 32'(sum1), 32'(es));
    check("d1_cout", 32'(cout1), 32'(ec));
    check("d1_err", 32'(err1), 32'(ee));
    check("d1_ov", 32'(ov1), 32'd1);
  endtask

  task automatic op4(input logic [15:0] a, input logic [15:0] b, input logic c,
                     input logic [15:0] es, input logic ec);
    @(negedge clk);
    a4 = a; b4 = b; cin4 = c; v4 = 1'b1;
    @(posedge clk); #1;
    $display("d4 %h+%h+%0d -> sum %h cout %0d", a, b, c, sum4, cout4);
    check("d4_sum", 32'(sum4), 32'(es));
    check("d4_cout", 32'(cout4), 32'(ec));
    check("d4_err", 32'(err4), 32'd0);
    check("d4_ov", 32'(ov4), 32'd1);
    @(negedge clk);
    v4 = 1'b0;
  endtask

  initial begin
    int t;
    rst = 1'b1;
    v1 = 1'b1; a1 = 4'd7; b1 = 4'd8; cin1 = 1'b1;
    v4 = 1'b1; a4 = 16'h1234; b4 = 16'h5678; cin4 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    $display("reset: sum1 %0h ov1 %0d sum4 %h ov4 %0d", sum1, ov1, sum4, ov4);
    check("rst_sum1", 32'(sum1), 32'd0);
    check("rst_cout1", 32'(cout1), 32'd0);
    check("rst_ov1", 32'(ov1), 32'd0);
    check("rst_err1", 32'(err1), 32'd0);
    check("rst_sum4", 32'(sum4), 32'd0);
    check("rst_cout4", 32'(cout4), 32'd0);
    check("rst_ov4", 32'(ov4), 32'd0);
    @(negedge clk);
    rst = 1'b0; v4 = 1'b0;

    // Directed single-digit vectors
    op1(4'd5, 4'd4, 1'b0, 4'd9, 1'b0, 1'b0);
    op1(4'd7, 4'd5, 1'b0, 4'd2, 1'b1, 1'b0);
    op1(4'd9, 4'd9, 1'b0, 4'd8, 1'b1, 1'b0);
    op1(4'd3, 4'd6, 1'b1, 4'd0, 1'b1, 1'b0);
    op1(4'd9, 4'd9, 1'b1, 4'd9, 1'b1, 1'b0);

    // Invalid digit: t = 10+1 = 11 -> (11+6) mod 16 = 1, carry 1, err flagged
    op1(4'hA, 4'd1, 1'b0, 4'h1, 1'b1, 1'b1);
    // Invalid at the top of the range: 15+15+1 = 31 -> 37 mod 16 = 5
    op1(4'hF, 4'hF, 1'b1, 4'h5, 1'b1, 1'b1);
    // A following valid operand clears err
    op1(4'd2, 4'd3, 1'b0, 4'd5, 1'b0, 1'b0);

    // Four-digit ripple
    op4(16'h9999, 16'h0000, 1'b1, 16'h0000, 1'b1);
    op4(16'h1234, 16'h8766, 1'b0, 16'h0000, 1'b1);
    op4(16'h0456, 16'h0789, 1'b0, 16'h1245, 1'b0);
    op4(16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1);

    // Hold behaviour with in_valid low and changing inputs
    op1(4'd7, 4'd5, 1'b0, 4'd2, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      v1 = 1'b0; a1 = 4'(k + 1); b1 = 4'(k + 4); cin1 = k[0];
      @(posedge clk); #1;
      $display("hold %0d: sum %0h cout %0d ov %0d", k, sum1, cout1, ov1);
      check("hold_ov", 32'(ov1), 32'd0);
      check("hold_sum", 32'(sum1), 32'd2);
      check("hold_cout", 32'(cout1), 32'd1);
    end

    // Reset mid-stream discards the in-flight result even with in_valid high
    @(negedge clk);
    v1 = 1'b1; a1 = 4'd4; b1 = 4'd4; cin1 = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    $display("mid reset: sum %0h ov %0d", sum1, ov1);
    check("midrst_ov", 32'(ov1), 32'd0);
    check("midrst_sum", 32'(sum1), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Exhaustive legal single-digit space, back to back
    for (int c = 0; c < 2; c++)
      for (int a = 0; a < 10; a++)
        for (int b = 0; b < 10; b++) begin
          t = a + b + c;
          op1(4'(a), 4'(b), c[0], 4'(t % 10), (t >= 10), 1'b0);
        end

    @(negedge clk);
    v1 = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
